// File: rtl/conv_mdc_job_sched_pkg.sv
// Shared types and default widths for the conv_mdc job sequencer.
//   sched_state_t : sequencer FSM states
//   sched_cfg_t   : job configuration as captured from the register file
//   sched_ctrl_t  : request/start pulses toward the streamers and engine
//   sched_flags_t : ready/done inputs from the streamers and engine
package conv_mdc_job_sched_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;
    localparam int TILE_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        RUN    = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] src_base;
        logic [ADDR_W_DEF-1:0] dst_base;
        logic [LEN_W_DEF-1:0]  tile_len;
        logic [TILE_W_DEF-1:0] n_tiles;
        logic [ADDR_W_DEF-1:0] stride;
    } sched_cfg_t;

    typedef struct packed {
        logic src_req_start;
        logic dst_req_start;
        logic eng_start;
    } sched_ctrl_t;

    typedef struct packed {
        logic src_ready;
        logic dst_ready;
        logic src_done;
        logic dst_done;
        logic eng_done;
    } sched_flags_t;

endpackage

// File: rtl/conv_mdc_job_sched_tile_addr_gen.sv
// Tile address generator for the conv_mdc job sequencer.
// Holds the latched job configuration, the tile counter and the src/dst
// address accumulators.
//   load_i     : capture bases/stride/len/count, restart at tile 0
//   step_i     : advance to the next tile (addresses += stride, wrapping)
//   clear_i    : synchronous return to the all-zero reset state
//   last_o     : current tile is the final tile of the job
//   src_addr_o, dst_addr_o, len_o, tile_idx_o : current tile parameters
module conv_mdc_tile_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int TILE_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [LEN_W-1:0]  tile_len_i,
    input  logic [TILE_W-1:0] n_tiles_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  len_q;
    logic [TILE_W-1:0] n_q;
    logic [TILE_W-1:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= '0;
            dst_q    <= '0;
            stride_q <= '0;
            len_q    <= '0;
            n_q      <= '0;
            idx_q    <= '0;
        end else if (clear_i) begin
            src_q    <= '0;
            dst_q    <= '0;
            stride_q <= '0;
            len_q    <= '0;
            n_q      <= '0;
            idx_q    <= '0;
        end else if (load_i) begin
            src_q    <= src_base_i;
            dst_q    <= dst_base_i;
            stride_q <= stride_i;
            len_q    <= tile_len_i;
            n_q      <= n_tiles_i;
            idx_q    <= '0;
        end else if (step_i) begin
            // Additions wrap naturally at ADDR_W bits.
            src_q <= src_q + stride_q;
            dst_q <= dst_q + stride_q;
            idx_q <= idx_q + TILE_W'(1);
        end
    end

    assign last_o     = (idx_q == (n_q - TILE_W'(1)));
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign len_o      = len_q;
    assign tile_idx_o = idx_q;

endmodule

// File: rtl/conv_mdc_job_sched.sv
// Job sequencer for the conv_mdc accelerator.
// A start_i pulse captures the job configuration; the sequencer then runs
// n_tiles tiles, each one issuing a source request, a sink request and an
// engine start together, and waiting for all three done pulses. One done_o
// pulse marks the end of the job. Zero tiles or zero length skips straight
// to completion.
// Ports:
//   clk_i, rst_ni, clear_i       : clock, async active-low reset, soft clear
//   start_i, cfg_*_i             : job trigger and configuration
//   *_ready_start_i, *_done_i    : streamer/engine handshake inputs
//   *_req_start_o, eng_start_o   : request/start pulses
//   src_addr_o, dst_addr_o, len_o, tile_idx_o : current tile parameters
//   busy_o, done_o               : job active, job-complete pulse
//   dbg_state_o                  : current FSM state encoding
//
// Request handshake: in ISSUE the three pulses fire together, for exactly
// one cycle, only in a cycle where src_ready_start_i and dst_ready_start_i
// are both high; the addresses and length are already stable at that point
// and stay stable until the tile completes.
module conv_mdc_job_sched
    import conv_mdc_job_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int TILE_W = TILE_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] cfg_src_base_i,
    input  logic [ADDR_W-1:0] cfg_dst_base_i,
    input  logic [LEN_W-1:0]  cfg_tile_len_i,
    input  logic [TILE_W-1:0] cfg_n_tiles_i,
    input  logic [ADDR_W-1:0] cfg_stride_i,
    input  logic              src_ready_start_i,
    input  logic              dst_ready_start_i,
    input  logic              src_done_i,
    input  logic              dst_done_i,
    input  logic              eng_done_i,
    output logic              src_req_start_o,
    output logic              dst_req_start_o,
    output logic              eng_start_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        dbg_state_o
);

    sched_state_t state_q, state_d;
    sched_ctrl_t  ctrl;
    sched_flags_t flags;

    logic       start_q;      // accepted trigger, one cycle of config settling
    logic       zero_q;       // captured job has no work
    logic [2:0] done_flag_q;  // sticky {src, dst, eng} done
    logic [2:0] done_all;
    logic       start_accept;
    logic       step;
    logic       issue_fire;
    logic       done_pulse;
    logic       last_tile;

    assign flags = '{src_ready: src_ready_start_i, dst_ready: dst_ready_start_i,
                     src_done:  src_done_i,        dst_done:  dst_done_i,
                     eng_done:  eng_done_i};

    // A trigger is taken only from a truly idle sequencer and never together
    // with a clear.
    assign start_accept = start_i && !clear_i && (state_q == IDLE) && !start_q;

    // Flags set in this very cycle count toward completion.
    assign done_all = done_flag_q | {flags.src_done, flags.dst_done, flags.eng_done};

    conv_mdc_tile_addr_gen #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .TILE_W(TILE_W)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .load_i    (start_accept),
        .step_i    (step),
        .src_base_i(cfg_src_base_i),
        .dst_base_i(cfg_dst_base_i),
        .tile_len_i(cfg_tile_len_i),
        .n_tiles_i (cfg_n_tiles_i),
        .stride_i  (cfg_stride_i),
        .src_addr_o(src_addr_o),
        .dst_addr_o(dst_addr_o),
        .len_o     (len_o),
        .tile_idx_o(tile_idx_o),
        .last_o    (last_tile)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            zero_q      <= 1'b0;
            done_flag_q <= '0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            zero_q      <= 1'b0;
            done_flag_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_accept;
            if (start_accept) begin
                zero_q <= (cfg_n_tiles_i == '0) || (cfg_tile_len_i == '0);
            end
            if (issue_fire) begin
                done_flag_q <= '0;
            end else if (state_q == RUN) begin
                done_flag_q <= done_all;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl       = '0;
        step       = 1'b0;
        issue_fire = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = zero_q ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (flags.src_ready && flags.dst_ready) begin
                    ctrl       = '{src_req_start: 1'b1, dst_req_start: 1'b1, eng_start: 1'b1};
                    issue_fire = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (&done_all) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (last_tile) begin
                    state_d = FINISH;
                end else begin
                    step    = 1'b1;
                    state_d = ISSUE;
                end
            end
            FINISH: begin
                done_pulse = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A clear suppresses every pulse in the cycle it is seen.
        if (clear_i) begin
            state_d    = IDLE;
            ctrl       = '0;
            step       = 1'b0;
            issue_fire = 1'b0;
            done_pulse = 1'b0;
        end
    end

    assign src_req_start_o = ctrl.src_req_start;
    assign dst_req_start_o = ctrl.dst_req_start;
    assign eng_start_o     = ctrl.eng_start;
    assign busy_o          = (state_q != IDLE) || start_q;
    assign done_o          = done_pulse;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_conv_mdc_job_sched.sv
module tb_conv_mdc_job_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] cfg_src_base_i = '0;
  logic [31:0] cfg_dst_base_i = '0;
  logic [15:0] cfg_tile_len_i = '0;
  logic [15:0] cfg_n_tiles_i = '0;
  logic [31:0] cfg_stride_i = '0;
  logic        src_ready_start_i = 1'b1;
  logic        dst_ready_start_i = 1'b1;
  logic        src_done_i = 1'b0;
  logic        dst_done_i = 1'b0;
  logic        eng_done_i = 1'b0;
  logic        src_req_start_o, dst_req_start_o, eng_start_o;
  logic [31:0] src_addr_o, dst_addr_o;
  logic [15:0] len_o, tile_idx_o;
  logic        busy_o, done_o;
  logic [2:0]  dbg_state_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Expected issue records {src, dst, len, tile_idx} and their cycles.
  logic [95:0] exp_q[$];
  int          iss_cyc_q[$];
  int          done_cyc_q[$];

  conv_mdc_job_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .cfg_src_base_i(cfg_src_base_i), .cfg_dst_base_i(cfg_dst_base_i),
    .cfg_tile_len_i(cfg_tile_len_i), .cfg_n_tiles_i(cfg_n_tiles_i),
    .cfg_stride_i(cfg_stride_i),
    .src_ready_start_i(src_ready_start_i), .dst_ready_start_i(dst_ready_start_i),
    .src_done_i(src_done_i), .dst_done_i(dst_done_i), .eng_done_i(eng_done_i),
    .src_req_start_o(src_req_start_o), .dst_req_start_o(dst_req_start_o),
    .eng_start_o(eng_start_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .len_o(len_o), .tile_idx_o(tile_idx_o), .busy_o(busy_o), .done_o(done_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives done pulses at the given cycle offsets from now; returns the
  // cycle of the last pulse. Leaves the bench one cycle past it.
  task automatic send_dones(input int ds, input int dd, input int de, output int last);
    int mx;
    int base;
    mx = ds;
    if (dd > mx) mx = dd;
    if (de > mx) mx = de;
    base = cyc;
    for (int k = 0; k <= mx; k++) begin
      src_done_i = (k == ds);
      dst_done_i = (k == dd);
      eng_done_i = (k == de);
      tick();
    end
    src_done_i = 1'b0;
    dst_done_i = 1'b0;
    eng_done_i = 1'b0;
    last = base + mx;
  endtask

  task automatic set_cfg(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                         input logic [15:0] n, input logic [31:0] stride);
    cfg_src_base_i = src;
    cfg_dst_base_i = dst;
    cfg_tile_len_i = len;
    cfg_n_tiles_i  = n;
    cfg_stride_i   = stride;
  endtask

  // Full job with hand-derived timing: issue 2 cycles after start (plus bp
  // cycles of dst back-pressure), next issue 2 cycles after the last done,
  // done_o 2 cycles after the last done of the final tile.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                         input logic [15:0] n, input logic [31:0] stride,
                         input int ds, input int dd, input int de, input int bp);
    int c;
    int issue;
    int d;
    set_cfg(src, dst, len, n, stride);
    if (bp > 0) dst_ready_start_i = 1'b0;
    start_i = 1'b1;
    c = cyc;
    tick();
    start_i = 1'b0;
    if (n == 16'd0 || len == 16'd0) begin
      done_cyc_q.push_back(c + 2);
      while (cyc < c + 5) tick();
      return;
    end
    issue = c + 2 + bp;
    d = 0;
    for (int t = 0; t < int'(n); t++) begin
      exp_q.push_back({src + stride * 32'(t), dst + stride * 32'(t), len, 16'(t)});
      iss_cyc_q.push_back(issue);
      while (cyc < issue) tick();
      dst_ready_start_i = 1'b1;
      tick();
      send_dones(ds, dd, de, d);
      issue = d + 2;
    end
    done_cyc_q.push_back(d + 2);
    while (cyc < d + 4) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (src_req_start_o || dst_req_start_o || eng_start_o) begin
        chk("issue_together", {src_req_start_o, dst_req_start_o, eng_start_o}, 3'b111);
        chk("issue_ready", {src_ready_start_i, dst_ready_start_i}, 2'b11);
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 1'b1, 1'b0);
        end else begin
          chk("issue_fields", {src_addr_o, dst_addr_o, len_o, tile_idx_o}, exp_q.pop_front());
          chk("issue_cycle", cyc, iss_cyc_q.pop_front());
        end
      end
      if (done_o) begin
        chk("done_busy", busy_o, 1'b1);
        if (done_cyc_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
        else chk("done_cycle", cyc, done_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int d;
    tick();
    tick();
    chk("rst_pulses", {src_req_start_o, dst_req_start_o, eng_start_o, busy_o, done_o}, 5'b0);
    chk("rst_addr", {src_addr_o, dst_addr_o}, 64'h0);
    chk("rst_len_idx", {len_o, tile_idx_o}, 32'h0);
    chk("rst_state", dbg_state_o, 3'd0);
    rst_ni = 1'b1;
    tick();

    // Single tile, dones dst -> src -> eng on separate cycles.
    run_job(32'h1000, 32'h2000, 16'd64, 16'd1, 32'h0, 1, 0, 2, 0);
    chk("single_idle", {busy_o, dbg_state_o}, 4'b0);
    // Three tiles with stride.
    run_job(32'h1000, 32'h2000, 16'd32, 16'd3, 32'h100, 0, 1, 2, 0);
    // Dst back-pressure for 10 cycles.
    run_job(32'h4000, 32'h5000, 16'd8, 16'd1, 32'h0, 0, 0, 0, 10);
    // Zero work: no tiles, then zero length.
    run_job(32'h1000, 32'h2000, 16'd64, 16'd0, 32'h100, 0, 0, 0, 0);
    run_job(32'h1000, 32'h2000, 16'd0, 16'd2, 32'h100, 0, 0, 0, 0);
    // All dones in one cycle, then eng -> dst -> src.
    run_job(32'h6000, 32'h7000, 16'd4, 16'd2, 32'h40, 0, 0, 0, 0);
    run_job(32'h6000, 32'h7000, 16'd4, 16'd2, 32'h40, 2, 1, 0, 0);
    // Address wrap.
    run_job(32'hFFFF_FF80, 32'h2000, 16'd8, 16'd2, 32'h100, 0, 1, 0, 0);

    // start_i mid-RUN is ignored.
    set_cfg(32'h3000, 32'h3800, 16'd16, 16'd1, 32'h0);
    start_i = 1'b1;
    c = cyc;
    tick();
    start_i = 1'b0;
    exp_q.push_back({32'h3000, 32'h3800, 16'd16, 16'd0});
    iss_cyc_q.push_back(c + 2);
    while (cyc < c + 3) tick();
    set_cfg(32'h9000, 32'h9800, 16'd99, 16'd5, 32'h10);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("abuse_start_cfg", {src_addr_o, dst_addr_o, len_o, tile_idx_o},
        {32'h3000, 32'h3800, 16'd16, 16'd0});
    send_dones(0, 0, 0, d);
    done_cyc_q.push_back(d + 2);
    while (cyc < d + 6) tick();

    // clear_i mid-RUN, with a start in the same cycle.
    set_cfg(32'h1000, 32'h2000, 16'd64, 16'd2, 32'h100);
    start_i = 1'b1;
    c = cyc;
    tick();
    start_i = 1'b0;
    exp_q.push_back({32'h1000, 32'h2000, 16'd64, 16'd0});
    iss_cyc_q.push_back(c + 2);
    while (cyc < c + 3) tick();
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("clear_state", {busy_o, dbg_state_o}, 4'b0);
    chk("clear_outputs", {src_addr_o, dst_addr_o, len_o, tile_idx_o}, 96'h0);
    send_dones(0, 0, 0, d);
    repeat (6) tick();
    chk("clear_stays_idle", {busy_o, dbg_state_o}, 4'b0);
    // Fresh job after clear.
    run_job(32'h1000, 32'h2000, 16'd64, 16'd2, 32'h100, 1, 0, 0, 0);

    // Asynchronous reset mid-RUN.
    set_cfg(32'hA000, 32'hB000, 16'd8, 16'd3, 32'h20);
    start_i = 1'b1;
    c = cyc;
    tick();
    start_i = 1'b0;
    exp_q.push_back({32'hA000, 32'hB000, 16'd8, 16'd0});
    iss_cyc_q.push_back(c + 2);
    while (cyc < c + 3) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_state", {busy_o, dbg_state_o}, 4'b0);
    chk("arst_outputs", {src_addr_o, dst_addr_o, len_o, tile_idx_o}, 96'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    run_job(32'h1000, 32'h2000, 16'd64, 16'd1, 32'h0, 0, 0, 1, 0);

    repeat (4) tick();
    chk("issue_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_cyc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
